// File: rtl/event_seq_counter_pair.sv
// event_seq_counter_pair
//   Two independent counters sharing one clock:
//   - event counter: counts ev_enable pulses up to EV_MAX, flags the
//     terminal count for one cycle, then self-clears.
//   - sequence counter: after a start strobe, counts enabled cycles up to
//     SQ_MAX, emits a registered one-cycle done strobe, then idles.
//   Optional macro SEQ_BUSY_OUT_EN adds the sq_busy output (running flag).
module event_seq_counter_pair #(
   parameter int               EV_DW  = 8,
   parameter logic [EV_DW-1:0] EV_MAX = 8'h40,
   parameter int               SQ_DW  = 6,
   parameter logic [SQ_DW-1:0] SQ_MAX = 6'h3E
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ev_enable,
   output logic [EV_DW-1:0] ev_cntr,
   output logic             ev_strb,
   input  logic             sq_enable,
   input  logic             sq_start_strb,
   output logic [SQ_DW-1:0] sq_cntr,
   output logic             sq_strb
`ifdef SEQ_BUSY_OUT_EN
   ,
   output logic             sq_busy
`endif
);

   typedef enum logic {
      SQ_IDLE = 1'b0,
      SQ_RUN  = 1'b1
   } sq_state_t;

   logic [EV_DW-1:0] ev_cntr_reg;
   logic [EV_DW-1:0] ev_cntr_next;

   sq_state_t        sq_state_reg;
   sq_state_t        sq_state_next;
   logic [SQ_DW-1:0] sq_cntr_reg;
   logic [SQ_DW-1:0] sq_cntr_next;
   logic             sq_strb_reg;
   logic             sq_strb_next;
   logic             sq_terminal;

   // Event counter next value: terminal count wins and swallows that cycle's enable.
   always_comb begin
      ev_cntr_next = ev_cntr_reg;
      if (ev_cntr_reg == EV_MAX) begin
         ev_cntr_next = '0;
      end else if (ev_enable) begin
         ev_cntr_next = ev_cntr_reg + EV_DW'(1);
      end
   end

   // Event counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ev_cntr_reg <= '0;
      end else begin
         ev_cntr_reg <= ev_cntr_next;
      end
   end

   assign ev_cntr = ev_cntr_reg;
   assign ev_strb = (ev_cntr_reg == EV_MAX);

   assign sq_terminal = (sq_state_reg == SQ_RUN) && sq_enable && (sq_cntr_reg == SQ_MAX);

   // Sequence FSM next state: start beats terminal, which beats counting.
   always_comb begin
      sq_state_next = sq_state_reg;
      sq_cntr_next  = sq_cntr_reg;
      sq_strb_next  = sq_terminal;
      if (sq_start_strb) begin
         sq_state_next = SQ_RUN;
         sq_cntr_next  = '0;
      end else if (sq_terminal) begin
         sq_state_next = SQ_IDLE;
         sq_cntr_next  = '0;
      end else if ((sq_state_reg == SQ_RUN) && sq_enable) begin
         sq_cntr_next  = sq_cntr_reg + SQ_DW'(1);
      end
   end

   // Sequence FSM state, count and done-strobe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sq_state_reg <= SQ_IDLE;
         sq_cntr_reg  <= '0;
         sq_strb_reg  <= 1'b0;
      end else begin
         sq_state_reg <= sq_state_next;
         sq_cntr_reg  <= sq_cntr_next;
         sq_strb_reg  <= sq_strb_next;
      end
   end

   assign sq_cntr = sq_cntr_reg;
   assign sq_strb = sq_strb_reg;

`ifdef SEQ_BUSY_OUT_EN
   assign sq_busy = (sq_state_reg == SQ_RUN);
`endif

endmodule

// File: tb/tb_event_seq_counter_pair.sv
// Testbench for event_seq_counter_pair (default EV_MAX=0x40, SQ_MAX=0x3E)
// plus a second instance with SQ_MAX=0x0E for the short feedback period.
module tb_event_seq_counter_pair;

   logic       clk;
   logic       reset;
   logic       ev_enable;
   logic       sq_enable;
   logic       sq_start_strb;
   logic [7:0] ev_cntr;
   logic       ev_strb;
   logic [5:0] sq_cntr;
   logic       sq_strb;

   logic       sq_start_strb2;
   logic [7:0] ev_cntr2;
   logic       ev_strb2;
   logic [5:0] sq_cntr2;
   logic       sq_strb2;
`ifdef SEQ_BUSY_OUT_EN
   logic       sq_busy;
   logic       sq_busy2;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] exp_q[$];
   int          strb_q1[$];
   int          strb_q2[$];

   event_seq_counter_pair dut (
      .clk          (clk),
      .reset        (reset),
      .ev_enable    (ev_enable),
      .ev_cntr      (ev_cntr),
      .ev_strb      (ev_strb),
      .sq_enable    (sq_enable),
      .sq_start_strb(sq_start_strb),
      .sq_cntr      (sq_cntr),
      .sq_strb      (sq_strb)
`ifdef SEQ_BUSY_OUT_EN
      ,
      .sq_busy      (sq_busy)
`endif
   );

   event_seq_counter_pair #(.SQ_MAX(6'h0E)) dut_short (
      .clk          (clk),
      .reset        (reset),
      .ev_enable    (ev_enable),
      .ev_cntr      (ev_cntr2),
      .ev_strb      (ev_strb2),
      .sq_enable    (sq_enable),
      .sq_start_strb(sq_start_strb2),
      .sq_cntr      (sq_cntr2),
      .sq_strb      (sq_strb2)
`ifdef SEQ_BUSY_OUT_EN
      ,
      .sq_busy      (sq_busy2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] obs1();
      return {ev_cntr, ev_strb, sq_cntr, sq_strb};
   endfunction

   // Apply inputs, take one rising edge, settle 1 time unit past it.
   task automatic drive(input logic ev_en, input logic sq_en, input logic sq_st);
      ev_enable     = ev_en;
      sq_enable     = sq_en;
      sq_start_strb = sq_st;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      sq_start_strb2 = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      reset          = 1'b1;
      sq_start_strb2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(16'h0000);
         drive(1'b1, 1'b1, 1'b1);
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs1(), got);
         end
      end
      reset          = 1'b0;
      sq_start_strb2 = 1'b0;
      exp_q.push_back(16'h0000);
      drive(1'b0, 1'b0, 1'b0);
      got = exp_q.pop_front();
      checks++;
      if (obs1() !== got) begin
         errors++;
         $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs1(), got);
      end
      $display("test_reset done cyc=%0d", cyc);
   endtask

   task automatic test_ev_pulses();
      logic [15:0] got;
      do_reset();
      for (int k = 1; k <= 64; k++) begin
         for (int g = 0; g < ((k < 64) ? 64 : 3); g++) begin
            if (g == 0)
               exp_q.push_back({8'(k), (k == 64), 6'd0, 1'b0});
            else
               exp_q.push_back({((k == 64) ? 8'd0 : 8'(k)), 1'b0, 6'd0, 1'b0});
            drive((g == 0), 1'b0, 1'b0);
            got = exp_q.pop_front();
            checks++;
            if (obs1() !== got) begin
               errors++;
               $display("FAIL ev_pulses k=%0d g=%0d got=%h exp=%h", k, g, obs1(), got);
            end
         end
      end
      $display("test_ev_pulses done cyc=%0d", cyc);
   endtask

   task automatic test_ev_continuous();
      logic [15:0] got;
      int          v;
      do_reset();
      for (int i = 1; i <= 140; i++) begin
         v = i % 65;
         exp_q.push_back({8'(v), (v == 64), 6'd0, 1'b0});
         drive(1'b1, 1'b0, 1'b0);
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL ev_continuous i=%0d got=%h exp=%h", i, obs1(), got);
         end
      end
      $display("test_ev_continuous done cyc=%0d", cyc);
   endtask

   task automatic test_sq_single();
      logic [15:0] got;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(16'h0000);
         drive(1'b0, 1'b1, 1'b0);
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL sq_idle i=%0d got=%h exp=%h", i, obs1(), got);
         end
      end
      for (int j = 0; j <= 80; j++) begin
         exp_q.push_back({8'd0, 1'b0, ((j <= 62) ? 6'(j) : 6'd0), (j == 63)});
         drive(1'b0, 1'b1, (j == 0));
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL sq_single j=%0d got=%h exp=%h", j, obs1(), got);
         end
`ifdef SEQ_BUSY_OUT_EN
         checks++;
         if (sq_busy !== (j <= 62)) begin
            errors++;
            $display("FAIL sq_busy j=%0d got=%b exp=%b", j, sq_busy, (j <= 62));
         end
`endif
      end
      $display("test_sq_single done cyc=%0d", cyc);
   endtask

   task automatic test_sq_restart();
      logic [15:0] got;
      do_reset();
      for (int j = 0; j <= 20; j++) begin
         exp_q.push_back({8'd0, 1'b0, 6'(j), 1'b0});
         drive(1'b0, 1'b1, (j == 0));
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL sq_restart_pre j=%0d got=%h exp=%h", j, obs1(), got);
         end
      end
      for (int k = 0; k <= 70; k++) begin
         exp_q.push_back({8'd0, 1'b0, ((k <= 62) ? 6'(k) : 6'd0), (k == 63)});
         drive(1'b0, 1'b1, (k == 0));
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL sq_restart k=%0d got=%h exp=%h", k, obs1(), got);
         end
      end
      $display("test_sq_restart done cyc=%0d", cyc);
   endtask

   task automatic test_sq_enable_gap();
      logic [15:0] got;
      int          eff;
      do_reset();
      for (int j = 0; j <= 90; j++) begin
         eff = (j <= 30) ? j : ((j <= 35) ? 30 : j - 5);
         exp_q.push_back({8'd0, 1'b0, ((eff <= 62) ? 6'(eff) : 6'd0), (eff == 63)});
         drive(1'b0, !((j >= 31) && (j <= 35)), (j == 0));
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL sq_enable_gap j=%0d got=%h exp=%h", j, obs1(), got);
         end
      end
      $display("test_sq_enable_gap done cyc=%0d", cyc);
   endtask

   // Start lands on the same edge as the terminal count.
   task automatic test_back_to_back();
      logic [15:0] got;
      int          k;
      do_reset();
      for (int j = 0; j <= 140; j++) begin
         k = (j >= 63) ? j - 63 : j;
         exp_q.push_back({8'd0, 1'b0, ((j >= 126) ? 6'd0 : 6'(k)), ((j == 63) || (j == 126))});
         drive(1'b0, 1'b1, ((j == 0) || (j == 63)));
         got = exp_q.pop_front();
         checks++;
         if (obs1() !== got) begin
            errors++;
            $display("FAIL back_to_back j=%0d got=%h exp=%h", j, obs1(), got);
         end
      end
      $display("test_back_to_back done cyc=%0d", cyc);
   endtask

   task automatic test_feedback();
      int exp_cyc;
      int n1 = 0;
      int n2 = 0;
      do_reset();
      sq_start_strb2 = 1'b1;
      drive(1'b0, 1'b1, 1'b1);
      strb_q1.push_back(cyc + 63);
      strb_q2.push_back(cyc + 15);
      for (int i = 1; i <= 300; i++) begin
         sq_start_strb2 = sq_strb2;
         drive(1'b0, 1'b1, sq_strb);
         if (sq_strb) begin
            n1++;
            exp_cyc = (strb_q1.size() != 0) ? strb_q1.pop_front() : -1;
            checks++;
            if (cyc !== exp_cyc) begin
               errors++;
               $display("FAIL feedback64 strobe at cyc=%0d exp=%0d", cyc, exp_cyc);
            end
            strb_q1.push_back(cyc + 64);
         end else if ((strb_q1.size() != 0) && (cyc > strb_q1[0])) begin
            checks++;
            errors++;
            $display("FAIL feedback64 missed strobe cyc=%0d exp=%0d", cyc, strb_q1[0]);
            void'(strb_q1.pop_front());
         end
         if (sq_strb2) begin
            n2++;
            exp_cyc = (strb_q2.size() != 0) ? strb_q2.pop_front() : -1;
            checks++;
            if (cyc !== exp_cyc) begin
               errors++;
               $display("FAIL feedback16 strobe at cyc=%0d exp=%0d", cyc, exp_cyc);
            end
            strb_q2.push_back(cyc + 16);
         end else if ((strb_q2.size() != 0) && (cyc > strb_q2[0])) begin
            checks++;
            errors++;
            $display("FAIL feedback16 missed strobe cyc=%0d exp=%0d", cyc, strb_q2[0]);
            void'(strb_q2.pop_front());
         end
      end
      checks++;
      if (n1 !== 4) begin
         errors++;
         $display("FAIL feedback64_count got=%0d exp=4", n1);
      end
      checks++;
      if (n2 !== 18) begin
         errors++;
         $display("FAIL feedback16_count got=%0d exp=18", n2);
      end
      $display("test_feedback done cyc=%0d strobes64=%0d strobes16=%0d", cyc, n1, n2);
   endtask

   initial begin
      reset          = 1'b1;
      ev_enable      = 1'b0;
      sq_enable      = 1'b0;
      sq_start_strb  = 1'b0;
      sq_start_strb2 = 1'b0;
      test_reset();
      test_ev_pulses();
      test_ev_continuous();
      test_sq_single();
      test_sq_restart();
      test_sq_enable_gap();
      test_back_to_back();
      test_feedback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
